// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute-stage ALU with valid/ready handshake, flush and iterative shifter
// Optional feature macro: ALU_EXEC_FAST_SHIFT_EN selects a single-cycle barrel shifter.
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             invA,
    input  logic             invB,
    input  logic             cin,
    input  logic             sign,
    input  logic             passA,
    input  logic             passB,
    input  logic [2:0]       op_to_alu,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ofl,
    output logic             zero
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ofl;
    logic               r_zero;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [SW-1:0]      w_amt;
    logic [WIDTH:0]     w_sum;
    logic               w_accept;
    logic               w_iter;
    logic [WIDTH-1:0]   w_res;
    logic               w_cout;
    logic               w_ofl;

    assign w_a      = invA ? ~A : A;
    assign w_b      = invB ? ~B : B;
    assign w_amt    = B[SW-1:0];
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, cin};
    assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    localparam logic [SW:0] W_FULL = (SW+1)'(WIDTH);

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl_wrap;
    logic [WIDTH-1:0] w_shr_wrap;

    // The wrap-around term shifts by WIDTH for amount 0, which yields zero.
    assign w_shl      = w_a << w_amt;
    assign w_shr      = w_a >> w_amt;
    assign w_shl_wrap = w_a >> (W_FULL - {1'b0, w_amt});
    assign w_shr_wrap = w_a << (W_FULL - {1'b0, w_amt});
    assign w_iter     = 1'b0;
`else
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    logic [WIDTH-1:0] r_shreg;
    logic [SW-1:0]    r_cnt;
    logic [1:0]       r_sop;
    logic [WIDTH-1:0] w_step;

    assign w_iter = !passA && !passB && !op_to_alu[2] && (w_amt != '0);

    always_comb begin
        w_step = r_shreg;
        case (r_sop)
            2'b00:   w_step = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
            2'b01:   w_step = {r_shreg[WIDTH-2:0], 1'b0};
            2'b10:   w_step = {r_shreg[0], r_shreg[WIDTH-1:1]};
            default: w_step = {1'b0, r_shreg[WIDTH-1:1]};
        endcase
    end
`endif

    always_comb begin
        w_res  = w_a;
        w_cout = 1'b0;
        w_ofl  = 1'b0;
        if (passB) begin
            w_res = B;
        end else if (passA) begin
            w_res = A;
        end else begin
            case (op_to_alu)
`ifdef ALU_EXEC_FAST_SHIFT_EN
                3'b000: w_res = w_shl | w_shl_wrap;
                3'b001: w_res = w_shl;
                3'b010: w_res = w_shr | w_shr_wrap;
                3'b011: w_res = w_shr;
`endif
                3'b100: begin
                    w_res  = w_sum[WIDTH-1:0];
                    w_cout = w_sum[WIDTH];
                    w_ofl  = sign ? ((w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                                     (w_sum[WIDTH-1] != w_a[WIDTH-1]))
                                  : w_sum[WIDTH];
                end
                3'b101:  w_res = w_a | w_b;
                3'b110:  w_res = w_a ^ w_b;
                3'b111:  w_res = w_a & w_b;
                // Zero-amount shifts in the iterative build pass A' through.
                default: w_res = w_a;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_iter ? S_SHIFT : S_DONE;
                end
            end
`ifndef ALU_EXEC_FAST_SHIFT_EN
            S_SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ofl    <= 1'b0;
            r_zero   <= 1'b1;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_sop    <= 2'b00;
`endif
        end else if (flush) begin
`ifndef ALU_EXEC_FAST_SHIFT_EN
            r_cnt    <= '0;
`endif
        end else if (w_accept && !w_iter) begin
            r_result <= w_res;
            r_cout   <= w_cout;
            r_ofl    <= w_ofl;
            r_zero   <= (w_res == '0);
`ifndef ALU_EXEC_FAST_SHIFT_EN
        end else if (w_accept) begin
            r_shreg  <= w_a;
            r_cnt    <= w_amt;
            r_sop    <= op_to_alu[1:0];
        end else if (r_state == S_SHIFT) begin
            r_shreg  <= w_step;
            r_cnt    <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
                r_result <= w_step;
                r_cout   <= 1'b0;
                r_ofl    <= 1'b0;
                r_zero   <= (w_step == '0);
            end
`endif
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ofl    = r_ofl;
    assign zero   = r_zero;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard testbench for alu_exec with randomized and directed operations
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        invA, invB, cin, sign, passA, passB;
    logic [2:0]  op_to_alu;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout, ofl, zero;

    int          ntotal = 0;
    int          npass  = 0;
    logic [18:0] sb[$];

    alu_exec #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .invA(invA), .invB(invB), .cin(cin), .sign(sign),
        .passA(passA), .passB(passB), .op_to_alu(op_to_alu), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .ofl(ofl), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout ntotal=%0d", ntotal);
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        ntotal++;
        if (act === req) npass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op, input logic ia, input logic ib,
                                          input logic ci, input logic sg, input logic pa,
                                          input logic pb);
        logic [15:0] a2, b2;
        int ap, bp, n, r, s, ss;
        logic co, of;
        a2 = ia ? ~a : a;
        b2 = ib ? ~b : b;
        ap = int'(a2);
        bp = int'(b2);
        n  = int'(b[3:0]);
        co = 1'b0;
        of = 1'b0;
        r  = 0;
        if (pb) r = int'(b);
        else if (pa) r = int'(a);
        else begin
            case (op)
                3'd0: r = ((ap << n) | (ap >> (16 - n))) & 'hFFFF;
                3'd1: r = (ap << n) & 'hFFFF;
                3'd2: r = ((ap >> n) | (ap << (16 - n))) & 'hFFFF;
                3'd3: r = ap >> n;
                3'd4: begin
                    s  = ap + bp + int'(ci);
                    r  = s & 'hFFFF;
                    co = (s > 'hFFFF);
                    ss = int'($signed(a2)) + int'($signed(b2)) + int'(ci);
                    of = sg ? (ss > 32767 || ss < -32768) : co;
                end
                3'd5: r = ap | bp;
                3'd6: r = ap ^ bp;
                default: r = ap & bp;
            endcase
        end
        return {r[15:0], co, of, (r[15:0] == 16'h0)};
    endfunction

    function automatic int exp_latency(input logic [15:0] b, input logic [2:0] op,
                                       input logic pa, input logic pb);
`ifdef ALU_EXEC_FAST_SHIFT_EN
        return 1;
`else
        if (!pa && !pb && !op[2] && b[3:0] != 4'd0) return int'(b[3:0]) + 1;
        return 1;
`endif
    endfunction

    task automatic clr_inputs();
        in_valid = 0; A = 0; B = 0; invA = 0; invB = 0; cin = 0; sign = 0;
        passA = 0; passB = 0; op_to_alu = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic ia, input logic ib, input logic ci, input logic sg,
                        input logic pa, input logic pb, input int stall,
                        input logic has_exp, input logic [18:0] ex);
        int k, lat;
        sb.push_back(has_exp ? ex : model(a, b, op, ia, ib, ci, sg, pa, pb));
        lat = exp_latency(b, op, pa, pb);
        check("in_ready_before_accept", in_ready, 1);
        A = a; B = b; op_to_alu = op; invA = ia; invB = ib; cin = ci; sign = sg;
        passA = pa; passB = pb; in_valid = 1; out_ready = 0;
        step();
        in_valid = 0;
        check("in_ready_after_accept", in_ready, 0);
        k = 1;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        check("latency", k, lat);
        repeat (stall) begin
            step();
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1;
        step();
        out_ready = 0;
        check("in_ready_after_handshake", in_ready, 1);
        check("out_valid_after_handshake", out_valid, 0);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks held outputs under backpressure.
    logic        hold_q = 1'b0;
    logic [15:0] hold_res;
    logic [2:0]  hold_flags;
    always @(negedge clk) begin
        logic [18:0] e;
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q && out_valid) begin
                check("hold_result", result, hold_res);
                check("hold_flags", {cout, ofl, zero}, hold_flags);
            end
            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    ntotal++;
                    $display("FAIL unexpected_output actual=%0h required=none", result);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e[18:3]);
                    check("cout", cout, e[2]);
                    check("ofl", ofl, e[1]);
                    check("zero", zero, e[0]);
                end
            end
            hold_q     = out_valid && !out_ready && !flush;
            hold_res   = result;
            hold_flags = {cout, ofl, zero};
        end
    end

    initial begin
        logic seen;
        clr_inputs();
        out_ready = 0;
        rst = 1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ofl", ofl, 0);
        check("rst_zero", zero, 1);
        #10;
        rst = 0;
        step();
        check("rst_in_ready", in_ready, 1);

        send(16'h7FFF, 16'h0001, 3'd4, 0, 0, 0, 1, 0, 0, 0, 1, {16'h8000, 1'b0, 1'b1, 1'b0});
        send(16'h7FFF, 16'h0001, 3'd4, 0, 0, 0, 0, 0, 0, 0, 1, {16'h8000, 1'b0, 1'b0, 1'b0});
        send(16'h0005, 16'h0005, 3'd4, 1, 0, 1, 0, 0, 0, 0, 1, {16'h0000, 1'b1, 1'b1, 1'b1});
        send(16'h8001, 16'h0005, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1, {16'h0030, 1'b0, 1'b0, 1'b0});
        send(16'h0000, 16'hFF80, 3'd1, 0, 0, 0, 0, 0, 1, 0, 1, {16'hFF80, 1'b0, 1'b0, 1'b0});
        send(16'h1234, 16'h0000, 3'd1, 0, 0, 0, 0, 0, 0, 0, 1, {16'h1234, 1'b0, 1'b0, 1'b0});
        send(16'h00FF, 16'h0F0F, 3'd6, 0, 0, 0, 0, 0, 0, 5, 1, {16'h0FF0, 1'b0, 1'b0, 1'b0});

        // Flush at cycle 3 of an SRL by 10.
        A = 16'hF0F0; B = 16'h000A; op_to_alu = 3'd3; in_valid = 1;
        step();
        in_valid = 0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
        check("flush_c1_out_valid", out_valid, 0);
`endif
        step();
`ifndef ALU_EXEC_FAST_SHIFT_EN
        check("flush_c2_out_valid", out_valid, 0);
`endif
        step();
        flush = 1; in_valid = 1; op_to_alu = 3'd4;
        step();
        flush = 0; in_valid = 0;
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid", out_valid, 0);
        // Flush in IDLE wins over in_valid: nothing may be accepted.
        flush = 1; in_valid = 1;
        step();
        flush = 0; in_valid = 0;
        seen = 0;
        repeat (14) begin
            step();
            seen |= out_valid;
        end
        check("flush_never_valid", seen, 0);

        send(16'h0000, 16'hFF80, 3'd0, 0, 0, 0, 0, 0, 1, 0, 1, {16'hFF80, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset in the middle of an SLL by 8.
        A = 16'h00FF; B = 16'h0008; op_to_alu = 3'd1; in_valid = 1;
        step();
        in_valid = 0;
        repeat (3) step();
        #2;
        rst = 1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_cout", cout, 0);
        check("midrst_ofl", ofl, 0);
        check("midrst_zero", zero, 1);
        @(negedge clk);
        #1;
        rst = 0;
        step();
        seen = 0;
        repeat (12) begin
            step();
            seen |= out_valid;
        end
        check("midrst_never_valid", seen, 0);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] ra, rb;
            logic [2:0]  rop;
            logic [5:0]  ctl;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = 3'($urandom_range(0, 7));
            ctl = 6'($urandom);
            send(ra, rb, rop, ctl[0], ctl[1], ctl[2], ctl[3],
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 3)), 0, 19'h0);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU for the 16-bit processor datapath. It consumes the decoded control word (`invA`, `invB`, `sign`, `op_to_alu`, `cin`, `passA`, `passB`) produced by the ALU control decoder, together with both operands, and returns a registered result with flags.

- Add and logic ops complete in one cycle.
- Rotates and shifts run on an iterative 1-bit/cycle shifter unless the fast shifter is compiled in.
- A valid/ready handshake on both sides lets the pipeline stall around multi-cycle shifts.
- A flush aborts an in-flight op on a branch redirect.

## Interface
Parameters:
- `WIDTH`, 16, datapath width. Shift amount width is log2(`WIDTH`), i.e. 4 bits.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: block can accept. High only in IDLE.
- `A` in WIDTH: operand A (data for shifts).
- `B` in WIDTH: operand B. `B[3:0]` is the shift amount.
- `invA`, `invB`, `cin`, `sign`, `passA`, `passB` in 1 each: control from ALU control.
- `op_to_alu` in 3: 000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 ADD, 101 OR, 110 XOR, 111 AND.
- `flush` in 1: synchronous abort.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `result` out WIDTH: registered result.
- `cout` out 1: adder carry-out (0 for non-add ops).
- `ofl` out 1: overflow.
- `zero` out 1: `result == 0`.

## Operation
- Operands are captured on accept (`in_valid && in_ready && !flush`).
- `A' = invA ? ~A : A`; `B' = invB ? ~B : B`. The shift amount always comes from raw `B[3:0]`.
- Result priority:
  - `passB` gives `B`.
  - Otherwise `passA` gives `A`.
  - Otherwise the result is selected by `op_to_alu`.
- ADD: `{cout, sum} = A' + B' + cin`, computed at WIDTH+1 bits.
  - With `sign`=1, `ofl` = signed overflow (`A'[15]==B'[15]` and `sum[15]!=A'[15]`).
  - With `sign`=0, `ofl = cout`.
  - Non-add ops: `cout = 0`, `ofl = 0`.
- Logic ops act on `A'` and `B'`.
- Shifts use `A'` as data:
  - ROL/ROR rotate.
  - SLL/SRL shift with zero fill.
  - Amount 0 gives `A'` unchanged.
- `zero` is registered with `result`.
- State machine:
  - IDLE:
    - Non-shift accept, shift with amount 0, or any shift when the fast shifter is compiled in: compute, go to DONE.
    - Shift with amount n>0 (iterative shifter): load the shift register with `A'`, set the counter to n, go to SHIFT.
  - SHIFT: each cycle shift 1 bit in the latched direction/type and decrement the counter. When the counter reaches 0, go to DONE.
  - DONE: `out_valid`=1. Outputs are held stable until `out_ready`=1, then go to IDLE.
- `flush` from any state: return to IDLE, `out_valid`=0, no accept that cycle. `flush` wins over `in_valid` and over `out_ready`.
- Reset mid-operation aborts immediately. There is no partial result.

## Timing
- Reset values: `in_ready`=1 once `rst` deasserts (IDLE), `out_valid`=0, `result`=0, `cout`=0, `ofl`=0, `zero`=1, counter=0.
- Non-shift latency: accept in cycle 0, `out_valid` in cycle 1.
- Iterative shift by n>0: `out_valid` in cycle n+1.
- `in_ready` is low from the cycle after accept until the cycle after the DONE handshake. There is no back-to-back overlap; peak throughput is one op per 2 cycles.
- `out_valid` stays high and `result`/flags stay unchanged for as long as `out_ready`=0.
- A flush in the same cycle as the DONE handshake discards the result. The consumer must ignore it.

## Configuration
- `ALU_EXEC_FAST_SHIFT_EN`:
  - Defined: a combinational barrel shifter is used, every op has 1-cycle latency, and the SHIFT state and counter are removed.
  - Undefined: the iterative shifter runs, with latency n+1 for shift amount n.
- Functional results are identical in both builds.

## Test plan
- ADD: `A`=0x7FFF, `B`=0x0001, `sign`=1, `op`=100 → `result`=0x8000, `ofl`=1, `cout`=0, `zero`=0. With `sign`=0 → `ofl`=0.
- SUB: `invA`=1, `cin`=1, `A`=0x0005, `B`=0x0005 → `result`=0x0000, `zero`=1, `cout`=1.
- ROL: `A`=0x8001, `B`=0x0005, `op`=000 → `result`=0x0030. `out_valid` at cycle 6 (iterative) or cycle 1 (fast).
- LBI: `passB`=1, `B`=0xFF80 → `result`=0xFF80 after 1 cycle. SLL by 0 on `A`=0x1234 → 0x1234 after 1 cycle.
- Backpressure: hold `out_ready`=0 for 5 cycles after XOR 0x00FF^0x0F0F → `result` held at 0x0FF0, `in_ready`=0 throughout, returns to 1 the cycle after the handshake.
- Flush at cycle 3 of an SRL-by-10 → `out_valid` never asserts, `in_ready`=1 next cycle. Repeat with `rst` pulsed mid-shift → all outputs at reset values immediately.
